enigma_core: RTL and testbench



---
 rtl/enigma_core.sv | 225 ++++++++++++++++++++++
 tb/tb_enigma_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_core.sv
// enigma_core: N-rotor rotor cipher. The rotors, the reflector and the return
// path share one substitution datapath that is stepped by a small FSM. Wiring,
// positions and notches can be rewritten at run time while the core is idle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid / ready       character handshake (ready only while idle)
//   din / dout / done   ASCII in, ASCII out (held), one-cycle result pulse
//   cfg_we, cfg_kind    config strobe; kind 0=wiring 1=position 2=notch 3=none
//   cfg_slot            rotor index, NUM_ROTORS selects the reflector (wiring)
//   cfg_addr, cfg_data  wiring input/output letter, or position/notch value
//   pos_out             rotor positions, rotor i in bits [5i+4:5i]
//
// Build option: define ENIGMA_DOUBLE_STEP_EN for historical double stepping of
// the middle rotors; without it the rotors step like a plain odometer.

module enigma_core #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int SLOT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  output logic                    ready,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic                    done,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_kind,
  input  logic [SLOT_W-1:0]       cfg_slot,
  input  logic [4:0]              cfg_addr,
  input  logic [4:0]              cfg_data,
  output logic [5*NUM_ROTORS-1:0] pos_out
);

  localparam int IDX_W = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
  localparam logic [IDX_W-1:0]  LAST_ROT  = IDX_W'(NUM_ROTORS - 1);
  localparam logic [SLOT_W-1:0] REFL_SLOT = SLOT_W'(NUM_ROTORS);

  typedef enum logic [2:0] {IDLE, FWD, REFL, BWD, OUT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rot_q, rot_d;
  logic [4:0]       x_q, x_d;
  logic [7:0]       char_q, char_d;
  logic             letter_q, letter_d;
  logic [7:0]       dout_q, dout_d;
  logic             done_q, done_d;

  logic [4:0] fwd_q   [NUM_ROTORS][ALPHA];
  logic [4:0] fwd_d   [NUM_ROTORS][ALPHA];
  logic [4:0] inv_q   [NUM_ROTORS][ALPHA];
  logic [4:0] inv_d   [NUM_ROTORS][ALPHA];
  logic [4:0] refl_q  [ALPHA];
  logic [4:0] refl_d  [ALPHA];
  logic [4:0] pos_q   [NUM_ROTORS];
  logic [4:0] pos_d   [NUM_ROTORS];
  logic [4:0] notch_q [NUM_ROTORS];
  logic [4:0] notch_d [NUM_ROTORS];

  logic [NUM_ROTORS-1:0] at_notch;
  logic [NUM_ROTORS-1:0] step;
  logic [IDX_W-1:0]      slot_idx;
  logic [4:0]            rot_pos;

  // Mod-26 helpers: 6-bit intermediate with a single conditional correction.
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[4:0];
  endfunction

  assign ready    = (state_q == IDLE);
  assign dout     = dout_q;
  assign done     = done_q;
  assign slot_idx = cfg_slot[IDX_W-1:0];
  assign rot_pos  = pos_q[rot_q];

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pos
    assign pos_out[5*g +: 5] = pos_q[g];
  end

  // Which rotors advance if a letter is accepted now. A rotor carries into its
  // neighbour only when it steps itself while sitting on its notch; the
  // optional double step lets a middle rotor on its notch kick itself and the
  // next rotor regardless of the carry coming from below.
  always_comb begin
    at_notch = '0;
    step     = '0;
    for (int i = 0; i < NUM_ROTORS; i++) at_notch[i] = (pos_q[i] == notch_q[i]);
    step[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) step[i] = step[i-1] & at_notch[i-1];
`ifdef ENIGMA_DOUBLE_STEP_EN
    for (int i = 1; i < NUM_ROTORS - 1; i++) begin
      if (at_notch[i]) begin
        step[i]   = 1'b1;
        step[i+1] = 1'b1;
      end
    end
`endif
  end

  // Next-state logic: config writes and accepts while idle, then one
  // substitution per cycle through rotors, reflector and rotors in reverse.
  always_comb begin
    state_d  = state_q;
    rot_d    = rot_q;
    x_d      = x_q;
    char_d   = char_q;
    letter_d = letter_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    fwd_d    = fwd_q;
    inv_d    = inv_q;
    refl_d   = refl_q;
    pos_d    = pos_q;
    notch_d  = notch_q;

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (cfg_data <= 5'd25) begin
            case (cfg_kind)
              2'd0: begin
                if (cfg_addr <= 5'd25) begin
                  if (cfg_slot < REFL_SLOT) begin
                    fwd_d[slot_idx][cfg_addr] = cfg_data;
                    inv_d[slot_idx][cfg_data] = cfg_addr;
                  end else if (cfg_slot == REFL_SLOT) begin
                    refl_d[cfg_addr] = cfg_data;
                  end
                end
              end
              2'd1: if (cfg_slot < REFL_SLOT) pos_d[slot_idx] = cfg_data;
              2'd2: if (cfg_slot < REFL_SLOT) notch_d[slot_idx] = cfg_data;
              default: ;
            endcase
          end
        end else if (valid) begin
          char_d  = din;
          rot_d   = '0;
          state_d = FWD;
          // For 'A'..'Z' the low five bits are the letter index plus one.
          if (din >= 8'd65 && din <= 8'd90) begin
            letter_d = 1'b1;
            x_d      = din[4:0] - 5'd1;
            for (int i = 0; i < NUM_ROTORS; i++) begin
              if (step[i]) pos_d[i] = (pos_q[i] == 5'd25) ? 5'd0 : pos_q[i] + 5'd1;
            end
          end else begin
            letter_d = 1'b0;
            x_d      = 5'd0;
          end
        end
      end
      FWD: begin
        x_d = sub26(fwd_q[rot_q][add26(x_q, rot_pos)], rot_pos);
        if (rot_q == LAST_ROT) state_d = REFL;
        else rot_d = rot_q + 1'b1;
      end
      REFL: begin
        x_d     = refl_q[x_q];
        rot_d   = LAST_ROT;
        state_d = BWD;
      end
      BWD: begin
        x_d = sub26(inv_q[rot_q][add26(x_q, rot_pos)], rot_pos);
        if (rot_q == '0) state_d = OUT;
        else rot_d = rot_q - 1'b1;
      end
      OUT: begin
        dout_d  = letter_q ? ({3'b000, x_q} + 8'd65) : char_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and table registers; reset restores identity rotors, the x^1
  // reflector, zero positions and notches at 25, abandoning any character.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rot_q    <= '0;
      x_q      <= '0;
      char_q   <= '0;
      letter_q <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      for (int r = 0; r < NUM_ROTORS; r++) begin
        pos_q[r]   <= 5'd0;
        notch_q[r] <= 5'd25;
        for (int a = 0; a < ALPHA; a++) begin
          fwd_q[r][a] <= 5'(a);
          inv_q[r][a] <= 5'(a);
        end
      end
      for (int a = 0; a < ALPHA; a++) refl_q[a] <= 5'(a ^ 1);
    end else begin
      state_q  <= state_d;
      rot_q    <= rot_d;
      x_q      <= x_d;
      char_q   <= char_d;
      letter_q <= letter_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      fwd_q    <= fwd_d;
      inv_q    <= inv_d;
      refl_q   <= refl_d;
      pos_q    <= pos_d;
      notch_q  <= notch_d;
    end
  end

endmodule

// File: tb/tb_enigma_core.sv
// Self-checking bench for enigma_core (3 rotors). A letter-level reference
// model (plain mod-26 arithmetic over lookup arrays) predicts every result.

module tb_enigma_core;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         ready;
  logic [7:0]   din = 8'd0;
  logic [7:0]   dout;
  logic         done;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_kind = 2'd0;
  logic [3:0]   cfg_slot = 4'd0;
  logic [4:0]   cfg_addr = 5'd0;
  logic [4:0]   cfg_data = 5'd0;
  logic [5*N-1:0] pos_out;

  int checks = 0;
  int passes = 0;

  int m_fwd [N][26];
  int m_inv [N][26];
  int m_refl [26];
  int m_pos [N];
  int m_notch [N];

  enigma_core #(.NUM_ROTORS(N), .ALPHA(26), .SLOT_W(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .din(din),
    .dout(dout), .done(done), .cfg_we(cfg_we), .cfg_kind(cfg_kind),
    .cfg_slot(cfg_slot), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_pos[r] = 0;
      m_notch[r] = 25;
      for (int a = 0; a < 26; a++) begin
        m_fwd[r][a] = a;
        m_inv[r][a] = a;
      end
    end
    for (int a = 0; a < 26; a++) m_refl[a] = a ^ 1;
  endtask

  task automatic model_cfg(input int kind, input int slot, input int addr, input int data);
    if (data > 25) return;
    if (kind == 0 && addr <= 25) begin
      if (slot < N) begin
        m_fwd[slot][addr] = data;
        m_inv[slot][data] = addr;
      end else if (slot == N) m_refl[addr] = data;
    end else if (kind == 1 && slot < N) m_pos[slot] = data;
    else if (kind == 2 && slot < N) m_notch[slot] = data;
  endtask

  // Step the model rotors, then run the letter through the whole machine.
  task automatic model_char(input logic [7:0] c, output logic [7:0] res);
    bit adv [N];
    int x;
    if (c < 65 || c > 90) begin
      res = c;
      return;
    end
    adv[0] = 1'b1;
    for (int i = 1; i < N; i++) adv[i] = adv[i-1] && (m_pos[i-1] == m_notch[i-1]);
`ifdef ENIGMA_DOUBLE_STEP_EN
    for (int i = 1; i < N - 1; i++)
      if (m_pos[i] == m_notch[i]) begin
        adv[i] = 1'b1;
        adv[i+1] = 1'b1;
      end
`endif
    for (int i = 0; i < N; i++) if (adv[i]) m_pos[i] = (m_pos[i] + 1) % 26;
    x = int'(c) - 65;
    for (int i = 0; i < N; i++) x = (m_fwd[i][(x + m_pos[i]) % 26] - m_pos[i] + 26) % 26;
    x = m_refl[x];
    for (int i = N - 1; i >= 0; i--) x = (m_inv[i][(x + m_pos[i]) % 26] - m_pos[i] + 26) % 26;
    res = 8'(x + 65);
  endtask

  function automatic logic [5*N-1:0] model_pos_vec();
    logic [5*N-1:0] v;
    for (int i = 0; i < N; i++) v[5*i +: 5] = 5'(m_pos[i]);
    return v;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic cfg_write(input int kind, input int slot, input int addr, input int data);
    wait_ready();
    cfg_we = 1'b1;
    cfg_kind = 2'(kind);
    cfg_slot = 4'(slot);
    cfg_addr = 5'(addr);
    cfg_data = 5'(data);
    model_cfg(kind, slot, addr, data);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Send one character, optionally poking a position write while busy (it
  // must be ignored), and check latency, result, positions and pulse width.
  task automatic applyStimulus(input logic [7:0] ch, input bit poke_cfg, output logic [7:0] got);
    logic [7:0] exp;
    int lat;
    bit seen;
    wait_ready();
    din = ch;
    valid = 1'b1;
    @(posedge clk);
    model_char(ch, exp);
    @(negedge clk);
    valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 4 * N + 10) begin
      if (poke_cfg && lat == 2) begin
        cfg_we = 1'b1;
        cfg_kind = 2'd1;
        cfg_slot = 4'd0;
        cfg_addr = 5'd0;
        cfg_data = 5'd13;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      cfg_we = 1'b0;
      if (done) seen = 1'b1;
    end
    checkOutput("done_latency", 64'(lat), 64'(2 * N + 2));
    checkOutput("dout", 64'(dout), 64'(exp));
    checkOutput("pos_out", 64'(pos_out), 64'(model_pos_vec()));
    got = dout;
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_pulse", 64'(done), 64'd0);
    checkOutput("dout_hold", 64'(dout), 64'(exp));
  endtask

  task automatic program_shift();
    for (int a = 0; a < 26; a++) cfg_write(0, 0, a, (a + 1) % 26);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] exp;
    logic [5*N-1:0] ds_exp;
    int perm [26];
    int tmp, j, cyc, done_cnt, last_cyc;

    apply_reset();
    $display("[TB] reset defaults");
    checkOutput("rst_ready", 64'(ready), 64'd1);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_dout", 64'(dout), 64'd0);
    checkOutput("rst_pos", 64'(pos_out), 64'd0);
    applyStimulus("A", 1'b0, got);
    checkOutput("A_to_B", 64'(got), 64'(8'h42));
    checkOutput("rot0_pos1", 64'(pos_out[4:0]), 64'd1);
    applyStimulus("C", 1'b0, got);
    checkOutput("C_to_D", 64'(got), 64'(8'h44));

    $display("[TB] wiring and reciprocity");
    apply_reset();
    program_shift();
    applyStimulus("A", 1'b0, got);
    checkOutput("shift_A_to_Z", 64'(got), 64'(8'h5A));
    apply_reset();
    program_shift();
    applyStimulus("Z", 1'b0, got);
    checkOutput("shift_Z_to_A", 64'(got), 64'(8'h41));

    $display("[TB] reset during forward pass");
    wait_ready();
    din = "Q";
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd1);
    checkOutput("abort_pos", 64'(pos_out), 64'd0);
    applyStimulus("A", 1'b0, got);
    checkOutput("abort_tables_default", 64'(got), 64'(8'h42));

    $display("[TB] carry");
    cfg_write(1, 0, 0, 25);
    applyStimulus("A", 1'b0, got);
    checkOutput("carry_pos", 64'(pos_out), 64'({5'd0, 5'd1, 5'd0}));
    applyStimulus("B", 1'b0, got);
    checkOutput("carry_pos2", 64'(pos_out), 64'({5'd0, 5'd1, 5'd1}));

    $display("[TB] pass-through");
    applyStimulus(8'h35, 1'b0, got);
    checkOutput("nonletter", 64'(got), 64'(8'h35));
    checkOutput("nonletter_pos", 64'(pos_out), 64'({5'd0, 5'd1, 5'd1}));

    $display("[TB] held valid");
    wait_ready();
    din = "A";
    valid = 1'b1;
    cyc = 0;
    done_cnt = 0;
    last_cyc = -1;
    while (done_cnt < 3 && cyc < 3 * (2 * N + 3) + 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        done_cnt++;
        model_char("A", exp);
        checkOutput("held_dout", 64'(dout), 64'(exp));
        checkOutput("held_pos", 64'(pos_out), 64'(model_pos_vec()));
        if (last_cyc >= 0) checkOutput("held_gap", 64'(cyc - last_cyc), 64'(2 * N + 3));
        last_cyc = cyc;
        if (done_cnt == 3) valid = 1'b0;
      end
    end
    valid = 1'b0;
    checkOutput("held_done_count", 64'(done_cnt), 64'd3);

    $display("[TB] config while busy");
    applyStimulus("K", 1'b1, got);
    applyStimulus("L", 1'b0, got);

    $display("[TB] double step");
    apply_reset();
    cfg_write(2, 1, 0, 0);
    cfg_write(1, 0, 0, 5);
    applyStimulus("A", 1'b0, got);
`ifdef ENIGMA_DOUBLE_STEP_EN
    ds_exp = {5'd1, 5'd1, 5'd6};
`else
    ds_exp = {5'd0, 5'd0, 5'd6};
`endif
    checkOutput("double_step_pos", 64'(pos_out), 64'(ds_exp));

    $display("[TB] random tables and text");
    cfg_write(0, 9, 3, 4);
    cfg_write(1, 1, 0, 27);
    cfg_write(3, 0, 0, 7);
    for (int r = 0; r <= N; r++) begin
      for (int a = 0; a < 26; a++) perm[a] = a;
      for (int a = 25; a > 0; a--) begin
        j = $urandom_range(0, a);
        tmp = perm[a];
        perm[a] = perm[j];
        perm[j] = tmp;
      end
      if (r < N) begin
        for (int a = 0; a < 26; a++) cfg_write(0, r, a, perm[a]);
        cfg_write(1, r, 0, $urandom_range(0, 25));
        cfg_write(2, r, 0, $urandom_range(0, 25));
      end else begin
        for (int k = 0; k < 13; k++) begin
          cfg_write(0, N, perm[2*k], perm[2*k+1]);
          cfg_write(0, N, perm[2*k+1], perm[2*k]);
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) applyStimulus(8'($urandom_range(32, 126)), 1'b0, got);
      else applyStimulus(8'(65 + $urandom_range(0, 25)), 1'b0, got);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
